// File: rtl/ifmap_row_framer_if.sv
// Pixel-in / IFMap-word-out bundle for the row framer.
// slave = framer side, master = source/FIFO side.
interface ifmap_row_framer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] din;
    logic                  din_valid;
    logic                  din_ready;
    logic                  buf_ready;
    logic [DATA_WIDTH+1:0] ifmap_out;
    logic                  ifmap_wen;

    modport slave (
        input  din, din_valid, buf_ready,
        output din_ready, ifmap_out, ifmap_wen
    );

    modport master (
        output din, din_valid, buf_ready,
        input  din_ready, ifmap_out, ifmap_wen
    );
endinterface

// File: rtl/ifmap_row_framer.sv
// Tags a raw pixel stream with end-of-row / end-of-frame flags
// and writes the 18-bit words into the IFMap FIFO.
module ifmap_row_framer #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] row_len,
    input  logic [LEN_WIDTH-1:0] num_rows,
    ifmap_row_framer_if.slave    bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 cfg_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  rows_q;
    logic [LEN_WIDTH-1:0]  col_cnt;
    logic [LEN_WIDTH-1:0]  row_cnt;
    logic [DATA_WIDTH+1:0] out_reg;
    logic                  reg_valid;

    logic cfg_zero;
    logic start_ok;
    logic accept;
    logic wen;
    logic last_col;
    logic last_row;

    assign cfg_zero = (row_len == '0) || (num_rows == '0);
    assign start_ok = (state == IDLE) && start && !cfg_zero;
    assign wen      = reg_valid && bus.buf_ready;
    assign accept   = bus.din_valid && bus.din_ready;
    assign last_col = (col_cnt == len_q - LEN_WIDTH'(1));
    assign last_row = (row_cnt == rows_q - LEN_WIDTH'(1));

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: frame runs until the end-of-frame word leaves.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (accept && last_col && last_row) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (wen) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: ready is combinational on buf_ready, no skid buffer.
    always_comb begin
        bus.din_ready = (state == STREAM) && (!reg_valid || bus.buf_ready);
        bus.ifmap_out = out_reg;
        bus.ifmap_wen = wen;
        busy          = (state != IDLE);
        frame_done    = (state == DRAIN) && wen;
    end

    // Config latch, position counters, output register, error pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q     <= '0;
            rows_q    <= '0;
            col_cnt   <= '0;
            row_cnt   <= '0;
            out_reg   <= '0;
            reg_valid <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= (state == IDLE) && start && cfg_zero;
            if (start_ok) begin
                len_q   <= row_len;
                rows_q  <= num_rows;
                col_cnt <= '0;
                row_cnt <= '0;
            end
            if (accept) begin
                out_reg   <= {last_col && last_row, last_col, bus.din};
                reg_valid <= 1'b1;
                if (last_col) begin
                    col_cnt <= '0;
                    if (!last_row) begin
                        row_cnt <= row_cnt + LEN_WIDTH'(1);
                    end
                end else begin
                    col_cnt <= col_cnt + LEN_WIDTH'(1);
                end
            end else if (wen) begin
                reg_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifmap_row_framer.sv
// Directed bench for ifmap_row_framer.
// Writes are logged on the falling edge and checked per frame.
module tb_ifmap_row_framer;

    logic       clk;
    logic       rstn;
    logic       start;
    logic [7:0] row_len;
    logic [7:0] num_rows;
    logic       busy;
    logic       frame_done;
    logic       cfg_err;

    ifmap_row_framer_if #(.DATA_WIDTH(16)) bus ();

    ifmap_row_framer #(
        .DATA_WIDTH(16),
        .LEN_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .row_len   (row_len),
        .num_rows  (num_rows),
        .bus       (bus.slave),
        .busy      (busy),
        .frame_done(frame_done),
        .cfg_err   (cfg_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [17:0] wq[$];
    int          fd_cnt;
    logic [17:0] fd_word;
    logic        fd_prev;
    logic        busy_after;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every FIFO write and the frame_done / busy relation.
    always @(negedge clk) begin
        if (fd_prev) begin
            busy_after <= busy;
        end
        fd_prev <= frame_done;
        if (bus.ifmap_wen) begin
            wq.push_back(bus.ifmap_out);
        end
        if (frame_done) begin
            fd_cnt <= fd_cnt + 1;
            if (bus.ifmap_wen) begin
                fd_word <= bus.ifmap_out;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        wq.delete();
        fd_cnt     = 0;
        fd_word    = '0;
        busy_after = 1'b1;
    endtask

    task automatic go(input logic [7:0] l, input logic [7:0] r);
        row_len  = l;
        num_rows = r;
        start    = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic push(input logic [15:0] d);
        int n;
        bus.din       = d;
        bus.din_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.din_ready && n < 50) begin
            cyc();
            n++;
        end
        if (n >= 50) chk("push_timeout", 0, 1);
        cyc();
        bus.din_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            cyc();
            n++;
        end
        if (n >= 100) chk("idle_timeout", 0, 1);
        cyc();
    endtask

    task automatic chk_q(input string tag, input logic [17:0] exp[$]);
        chk({tag, "_cnt"}, wq.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < wq.size()) begin
                chk($sformatf("%s_w%0d", tag, i), wq[i], exp[i]);
            end
        end
    endtask

    task automatic chk_fd(input string tag, input logic [17:0] w);
        chk({tag, "_fdcnt"}, fd_cnt, 1);
        chk({tag, "_fdword"}, fd_word, w);
        chk({tag, "_busy"}, busy_after, 1'b0);
    endtask

    initial begin
        logic [17:0] e[$];
        rstn          = 1'b0;
        start         = 1'b0;
        row_len       = '0;
        num_rows      = '0;
        bus.din       = '0;
        bus.din_valid = 1'b1;
        bus.buf_ready = 1'b1;
        fd_prev       = 1'b0;
        clr();
        repeat (3) cyc();

        // Reset state
        chk("rst_out", bus.ifmap_out, 0);
        chk("rst_wen", bus.ifmap_wen, 0);
        chk("rst_rdy", bus.din_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_err", cfg_err, 0);
        bus.din_valid = 1'b0;
        rstn = 1'b1;
        cyc();

        // Basic frame 3x2
        clr();
        go(8'd3, 8'd2);
        chk("b_busy", busy, 1);
        for (int i = 1; i <= 6; i++) push(16'(i));
        wait_idle();
        e = '{18'h00001, 18'h00002, 18'h10003,
              18'h00004, 18'h00005, 18'h30006};
        chk_q("basic", e);
        chk_fd("basic", 18'h30006);

        // Backpressure after word 2
        clr();
        go(8'd3, 8'd2);
        push(16'd1);
        push(16'd2);
        bus.buf_ready = 1'b0;
        bus.din       = 16'd3;
        bus.din_valid = 1'b1;
        repeat (4) begin
            #1;
            chk("bp_out", bus.ifmap_out, 18'h00002);
            chk("bp_wen", bus.ifmap_wen, 0);
            chk("bp_rdy", bus.din_ready, 0);
            cyc();
        end
        bus.buf_ready = 1'b1;
        for (int i = 3; i <= 6; i++) push(16'(i));
        wait_idle();
        chk_q("bp", e);
        chk_fd("bp", 18'h30006);

        // Degenerate config, then 1x1
        clr();
        go(8'd0, 8'd2);
        bus.din_valid = 1'b1;
        #1;
        chk("deg_err", cfg_err, 1);
        chk("deg_busy", busy, 0);
        chk("deg_rdy", bus.din_ready, 0);
        cyc();
        chk("deg_err_clr", cfg_err, 0);
        bus.din_valid = 1'b0;
        go(8'd1, 8'd1);
        chk("one_err", cfg_err, 0);
        push(16'hABCD);
        wait_idle();
        e = '{18'h3ABCD};
        chk_q("one", e);
        chk_fd("one", 18'h3ABCD);

        // Bubbly input 4x1
        clr();
        go(8'd4, 8'd1);
        for (int i = 1; i <= 4; i++) begin
            push(16'(8'h11 * i));
            cyc();
        end
        wait_idle();
        e = '{18'h00011, 18'h00022, 18'h00033, 18'h30044};
        chk_q("bub", e);
        chk_fd("bub", 18'h30044);

        // Mid-frame reset with a held word
        clr();
        go(8'd3, 8'd2);
        push(16'd1);
        push(16'd2);
        push(16'd3);
        bus.buf_ready = 1'b0;
        cyc();
        cyc();
        chk("mr_held", bus.ifmap_out, 18'h10003);
        rstn          = 1'b0;
        bus.buf_ready = 1'b1;
        #1;
        chk("mr_out", bus.ifmap_out, 0);
        chk("mr_wen", bus.ifmap_wen, 0);
        chk("mr_busy", busy, 0);
        repeat (2) cyc();
        rstn = 1'b1;
        cyc();
        e = '{18'h00001, 18'h00002};
        chk_q("mr", e);
        chk("mr_fd", fd_cnt, 0);
        clr();
        go(8'd3, 8'd2);
        for (int i = 7; i <= 12; i++) push(16'(i));
        wait_idle();
        e = '{18'h00007, 18'h00008, 18'h10009,
              18'h0000A, 18'h0000B, 18'h3000C};
        chk_q("mr2", e);
        chk_fd("mr2", 18'h3000C);

        // Start while busy is ignored
        clr();
        go(8'd2, 8'd2);
        push(16'h21);
        row_len  = 8'd1;
        num_rows = 8'd1;
        start    = 1'b1;
        push(16'h22);
        start = 1'b0;
        #1;
        chk("sb_err", cfg_err, 0);
        push(16'h23);
        push(16'h24);
        wait_idle();
        e = '{18'h00021, 18'h10022, 18'h00023, 18'h30024};
        chk_q("sb", e);
        chk_fd("sb", 18'h30024);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
